// File: rtl/cla_nibble_seq_adder.sv
// Multi-cycle WIDTH-bit adder that runs operands through one 4-bit carry-lookahead slice,
// one nibble per cycle, LSB first. Optional signed-overflow output under CLA_SEQ_OVF_EN.

module cla4_slice (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       P,
    output logic       G
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Every internal carry is a flat function of cin, g and p; no ripple between bits.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;
    assign P   = &p;
    assign G   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module cla_nibble_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef CLA_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if ((WIDTH < 4) || (WIDTH % 4 != 0)) begin : g_bad_width
            $error("cla_nibble_seq_adder: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW+1:0]    base;
    logic [3:0]       nib_sum;
    logic             nib_p;
    logic             nib_g;
    logic             nib_cout;

    assign base = {cnt, 2'b00};

    cla4_slice u_slice (
        .A   (a_reg[base +: 4]),
        .B   (b_reg[base +: 4]),
        .cin (carry),
        .sum (nib_sum),
        .P   (nib_p),
        .G   (nib_g)
    );

    assign nib_cout = nib_g | (nib_p & carry);

    // Handshake outputs decode state only, so in_valid/out_ready never reach an output combinationally.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values;
    // the operand registers are cleared on reset too, so nothing stale can leak into a later result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[base +: 4] <= nib_sum;
                    carry          <= nib_cout;
                    cnt            <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cout  <= nib_cout;
`ifdef CLA_SEQ_OVF_EN
                        // Carry into the MSB recovered from the MSB sum bit: c[W-1] = a ^ b ^ s.
                        ovf   <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ nib_sum[3]) ^ nib_cout;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Scoreboard bench for cla_nibble_seq_adder: WIDTH=16 directed cases plus WIDTH=4/32 random sweeps.
// Define CLA_SEQ_OVF_EN for both RTL and bench to also check ovf.

module tb_cla_nibble_seq_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_bus;
    logic [31:0] b_bus;
    logic        cin_bus;
    logic        in_valid;
    logic        out_ready;
    int          sel;

    logic        iv4, ir4, ov4, co4, bz4;
    logic [3:0]  s4;
    logic        iv16, ir16, ov16, co16, bz16;
    logic [15:0] s16;
    logic        iv32, ir32, ov32, co32, bz32;
    logic [31:0] s32;
`ifdef CLA_SEQ_OVF_EN
    logic        of4, of16, of32, o_ovf;
`endif

    logic        o_ready, o_valid, o_busy, o_cout;
    logic [31:0] o_sum;

    exp_t exp_q[$];
    int   lat_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic prev_valid = 1'b0;
    int   mon_t;
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign iv4  = in_valid && (sel == 0);
    assign iv16 = in_valid && (sel == 1);
    assign iv32 = in_valid && (sel == 2);

    cla_nibble_seq_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a_bus[3:0]), .b(b_bus[3:0]), .cin(cin_bus),
        .out_valid(ov4), .out_ready(out_ready), .sum(s4), .cout(co4),
`ifdef CLA_SEQ_OVF_EN
        .ovf(of4),
`endif
        .busy(bz4)
    );

    cla_nibble_seq_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a_bus[15:0]), .b(b_bus[15:0]), .cin(cin_bus),
        .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(co16),
`ifdef CLA_SEQ_OVF_EN
        .ovf(of16),
`endif
        .busy(bz16)
    );

    cla_nibble_seq_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .a(a_bus), .b(b_bus), .cin(cin_bus),
        .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32),
`ifdef CLA_SEQ_OVF_EN
        .ovf(of32),
`endif
        .busy(bz32)
    );

    always_comb begin
        o_ready = ir16;
        o_valid = ov16;
        o_busy  = bz16;
        o_cout  = co16;
        o_sum   = 32'(s16);
`ifdef CLA_SEQ_OVF_EN
        o_ovf   = of16;
`endif
        case (sel)
            0: begin
                o_ready = ir4; o_valid = ov4; o_busy = bz4; o_cout = co4; o_sum = 32'(s4);
`ifdef CLA_SEQ_OVF_EN
                o_ovf = of4;
`endif
            end
            2: begin
                o_ready = ir32; o_valid = ov32; o_busy = bz32; o_cout = co32; o_sum = s32;
`ifdef CLA_SEQ_OVF_EN
                o_ovf = of32;
`endif
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    function automatic int wid(input int s);
        return (s == 0) ? 4 : ((s == 1) ? 16 : 32);
    endfunction

    // Behavioural reference: plain unsigned addition in 64 bits.
    function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [63:0] mask;
        logic [63:0] s;
        exp_t        e;
        mask   = (64'd1 << w) - 64'd1;
        s      = (64'(x) & mask) + (64'(y) & mask) + 64'(c);
        e.sum  = 32'(s & mask);
        e.cout = s[w];
        e.ovf  = x[w-1] ^ y[w-1] ^ s[w-1] ^ s[w];
        return e;
    endfunction

    // Monitor: latency on each out_valid rise, result compare on each handshake.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (o_valid && !prev_valid) begin
                if (lat_q.size() == 0) check("unexpected_valid", 1, 0);
                else begin
                    mon_t = lat_q.pop_front();
                    check("latency", 64'(cyc - mon_t), 64'(wid(sel) / 4));
                end
            end
            if (o_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("sum", 64'(o_sum), 64'(mon_e.sum));
                    check("cout", 64'(o_cout), 64'(mon_e.cout));
`ifdef CLA_SEQ_OVF_EN
                    check("ovf", 64'(o_ovf), 64'(mon_e.ovf));
`endif
                end
            end
            prev_valid = o_valid;
        end
    end

    task automatic issue(input int s, input logic [31:0] x, input logic [31:0] y, input logic c, input bit rnd);
        int budget = 0;
        @(negedge clk);
        sel = s;
        #0;
        while (!o_ready && budget < 200) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            budget++;
        end
        if (!o_ready) check("in_ready_timeout", 0, 1);
        a_bus    = x;
        b_bus    = y;
        cin_bus  = c;
        in_valid = 1'b1;
        exp_q.push_back(model(wid(s), x, y, c));
        lat_q.push_back(cyc + 1);
        @(negedge clk);
        in_valid = 1'b0;
        a_bus    = $urandom;
        b_bus    = $urandom;
        cin_bus  = 1'($urandom_range(0, 1));
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain();
        int budget = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || !o_ready) && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sel       = 1;
        a_bus     = '0;
        b_bus     = '0;
        cin_bus   = 1'b0;
        #12;
        check("rst_in_ready", 64'(o_ready), 1);
        check("rst_out_valid", 64'(o_valid), 0);
        check("rst_busy", 64'(o_busy), 0);
        check("rst_sum", 64'(o_sum), 0);
        check("rst_cout", 64'(o_cout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add, with in_ready low from accept through the DONE cycle.
        issue(1, 32'h1234, 32'h4321, 1'b0, 0);
        check("busy_run", 64'(o_busy), 1);
        cnt = 0;
        while (!o_ready && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check("in_ready_low_cycles", 64'(cnt), 5);
        drain();

        // Carry rippling through all four nibbles.
        issue(1, 32'hFFFF, 32'h0001, 1'b0, 0);
        issue(1, 32'hFFFF, 32'h0000, 1'b1, 0);
        drain();

        // Backpressure with stray in_valid pulses carrying other operands.
        out_ready = 1'b0;
        issue(1, 32'h00FF, 32'h0F01, 1'b0, 0);
        in_valid = 1'b1;
        a_bus    = 32'hAAAA;
        b_bus    = 32'h5555;
        cnt = 0;
        while (!o_valid && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        if (!o_valid) check("bp_valid_timeout", 0, 1);
        repeat (3) begin
            check("bp_out_valid", 64'(o_valid), 1);
            check("bp_sum", 64'(o_sum), 64'h1000);
            check("bp_cout", 64'(o_cout), 0);
            check("bp_in_ready", 64'(o_ready), 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Asynchronous reset two cycles into RUN.
        issue(1, 32'h1111, 32'h2222, 1'b0, 0);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(o_valid), 0);
        check("midrst_in_ready", 64'(o_ready), 1);
        check("midrst_busy", 64'(o_busy), 0);
        check("midrst_sum", 64'(o_sum), 0);
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 32'h0001, 32'h0001, 1'b0, 0);
        drain();

        // Signed-overflow corners (sum/cout always, ovf when enabled).
        issue(1, 32'h7FFF, 32'h0001, 1'b0, 0);
        issue(1, 32'h8000, 32'h8000, 1'b0, 0);
        issue(1, 32'h1234, 32'h4321, 1'b0, 0);
        drain();

        // Random sweeps on the narrow and wide instances with random backpressure.
        for (int s = 0; s <= 2; s += 2) begin
            issue(s, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
            for (int i = 0; i < 1000; i++) begin
                issue(s, $urandom, $urandom, 1'($urandom_range(0, 1)), 1);
            end
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
